// File: rtl/cell_pkg.sv
// Shared types and helper functions for the precharged wired-bus cell.
// Lane data is combined byte by byte so one helper covers every lane width.
package cell_pkg;

  typedef enum logic [1:0] {IDLE, PRE, EVAL, HOLD} state_t;

  localparam logic MODE_OR  = 1'b0;
  localparam logic MODE_AND = 1'b1;
  localparam int   MAX_W    = 1024;

  // The precharge value is the identity of the wired function (OR: 0, AND: all-ones).
  function automatic logic [MAX_W-1:0] precharge_val(input logic mode, input int w);
    logic [MAX_W-1:0] v;
    v = '0;
    if (mode == MODE_AND) begin
      for (int b = 0; b < MAX_W; b++) begin
        if (b < w) v[b] = 1'b1;
      end
    end
    return v;
  endfunction

  function automatic logic [7:0] combine(input logic mode, input logic [7:0] a,
                                         input logic [7:0] b);
    return (mode == MODE_AND) ? (a & b) : (a | b);
  endfunction

endpackage

// File: rtl/cell_reach_net.sv
// Combinational reach network: merges every enabled driver within RADIUS of each lane
// onto that lane's precharge value, or falls back to the keeper for floating lanes.
module cell_reach_net
  import cell_pkg::*;
#(
  parameter int               LANES     = 12,
  parameter int               WIDTH     = 1,
  parameter int               RADIUS    = 9,
  parameter logic [LANES-1:0] PRECHARGE = {LANES{1'b1}},
  parameter logic             MODE      = MODE_OR
) (
  input  logic [LANES-1:0]         en,
  input  logic [LANES*WIDTH*8-1:0] data,
  input  logic [LANES*WIDTH*8-1:0] keeper,
  output logic [LANES*WIDTH*8-1:0] result,
  output logic [LANES-1:0]         stale
);

  localparam int               W       = WIDTH * 8;
  localparam logic [MAX_W-1:0] PV_FULL = precharge_val(MODE, W);
  localparam logic [W-1:0]     PV      = PV_FULL[W-1:0];

  logic [W-1:0] acc;
  logic         hit;

  // Starting every lane from the precharge value also gives the right identity for
  // non-precharged lanes, so only the "nobody drove me" case needs special handling.
  always_comb begin
    result = '0;
    stale  = '0;
    acc    = PV;
    hit    = 1'b0;
    for (int j = 0; j < LANES; j++) begin
      acc = PV;
      hit = 1'b0;
      for (int i = 0; i < LANES; i++) begin
        if (en[i] && (((i > j) ? (i - j) : (j - i)) <= RADIUS)) begin
          for (int b = 0; b < WIDTH; b++) begin
            acc[b*8 +: 8] = combine(MODE, acc[b*8 +: 8], data[i*W + b*8 +: 8]);
          end
          hit = 1'b1;
        end
      end
      if (PRECHARGE[j] || hit) begin
        result[j*W +: W] = acc;
      end else begin
        result[j*W +: W] = keeper[j*W +: W];
        stale[j]         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cell_wbus.sv
// Synchronous wired-bus cell: IDLE/PRE/EVAL/HOLD sequencer around the reach network,
// with a keeper that holds non-precharged lanes between transactions.
module cell_wbus
  import cell_pkg::*;
#(
  parameter int               LANES     = 12,
  parameter int               WIDTH     = 1,
  parameter int               RADIUS    = 9,
  parameter logic [LANES-1:0] PRECHARGE = {LANES{1'b1}},
  parameter logic             MODE      = MODE_OR
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [LANES-1:0]         drv_en,
  input  logic [LANES*WIDTH*8-1:0] drv_data,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [LANES*WIDTH*8-1:0] res_data,
  output logic [LANES-1:0]         res_stale
);

  localparam int W = WIDTH * 8;

  state_t                 state;
  logic [LANES-1:0]       en_q;
  logic [LANES*W-1:0]     data_q;
  logic [LANES*W-1:0]     keeper;
  logic [LANES*W-1:0]     nxt_data;
  logic [LANES-1:0]       nxt_stale;

  cell_reach_net #(
    .LANES    (LANES),
    .WIDTH    (WIDTH),
    .RADIUS   (RADIUS),
    .PRECHARGE(PRECHARGE),
    .MODE     (MODE)
  ) u_net (
    .en    (en_q),
    .data  (data_q),
    .keeper(keeper),
    .result(nxt_data),
    .stale (nxt_stale)
  );

  assign req_ready = (state == IDLE);
  assign res_valid = (state == HOLD);

  // PRE is a pure sequencing phase: the precharge/keeper base is folded into the
  // reach network and only captured at the end of EVAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      en_q      <= '0;
      data_q    <= '0;
      keeper    <= '0;
      res_data  <= '0;
      res_stale <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            en_q   <= drv_en;
            data_q <= drv_data;
            state  <= PRE;
          end
        end
        PRE: state <= EVAL;
        EVAL: begin
          res_data  <= nxt_data;
          res_stale <= nxt_stale;
          for (int j = 0; j < LANES; j++) begin
            if (!PRECHARGE[j]) keeper[j*W +: W] <= nxt_data[j*W +: W];
          end
          state <= HOLD;
        end
        HOLD: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cell_wbus.sv
// Scoreboarded bench for cell_wbus: three instances (OR full bus, AND radius 1,
// OR radius 0 with lane 0 kept) driven by a linear sequence of directed steps.
module tb_cell_wbus;

  localparam int L  = 12;
  localparam int DW = 96;

  typedef struct {
    int            k;
    logic [DW-1:0] data;
    logic [L-1:0]  stale;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid [3];
  logic          req_ready [3];
  logic [L-1:0]  drv_en    [3];
  logic [DW-1:0] drv_data  [3];
  logic          res_valid [3];
  logic          res_ready [3];
  logic [DW-1:0] res_data  [3];
  logic [L-1:0]  res_stale [3];

  int            total = 0;
  int            bad   = 0;
  exp_t          sb[$];
  logic [DW-1:0] km     [3];
  int            rad_of [3] = '{9, 1, 0};
  logic          mode_of[3] = '{1'b0, 1'b1, 1'b0};
  logic [L-1:0]  pre_of [3] = '{12'hFFF, 12'hFFF, 12'hFFE};
  logic [DW-1:0] obs;

  always #5 clk = ~clk;

  cell_wbus dut_or (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .drv_en(drv_en[0]), .drv_data(drv_data[0]), .res_valid(res_valid[0]),
    .res_ready(res_ready[0]), .res_data(res_data[0]), .res_stale(res_stale[0]));

  cell_wbus #(.RADIUS(1), .MODE(1'b1)) dut_and (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .drv_en(drv_en[1]), .drv_data(drv_data[1]), .res_valid(res_valid[1]),
    .res_ready(res_ready[1]), .res_data(res_data[1]), .res_stale(res_stale[1]));

  cell_wbus #(.RADIUS(0), .PRECHARGE(12'hFFE)) dut_kp (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .drv_en(drv_en[2]), .drv_data(drv_data[2]), .res_valid(res_valid[2]),
    .res_ready(res_ready[2]), .res_data(res_data[2]), .res_stale(res_stale[2]));

  task automatic checkValue(input string tag, input logic [DW-1:0] o, input logic [DW-1:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic checkBit(input string tag, input logic o, input logic e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, o, e);
    end
  endtask

  // Reference: each lane starts at its precharge value and absorbs every driver in reach.
  function automatic void model(input int k, input logic [L-1:0] en, input logic [DW-1:0] d,
                                output logic [DW-1:0] r, output logic [L-1:0] st);
    r  = '0;
    st = '0;
    for (int j = 0; j < L; j++) begin
      logic [7:0] v;
      bit any;
      any = 0;
      v   = mode_of[k] ? 8'hFF : 8'h00;
      for (int i = 0; i < L; i++) begin
        if (en[i] && (i - j) <= rad_of[k] && (j - i) <= rad_of[k]) begin
          any = 1;
          v   = mode_of[k] ? (v & d[i*8 +: 8]) : (v | d[i*8 +: 8]);
        end
      end
      if (pre_of[k][j] || any) r[j*8 +: 8] = v;
      else begin
        r[j*8 +: 8] = km[k][j*8 +: 8];
        st[j]       = 1'b1;
      end
      if (!pre_of[k][j]) km[k][j*8 +: 8] = r[j*8 +: 8];
    end
  endfunction

  // Called #1 after a rising edge; returns #1 after the accept edge.
  task automatic applyStimulus(input int k, input logic [L-1:0] en, input logic [DW-1:0] d);
    exp_t          e;
    logic [DW-1:0] r;
    logic [L-1:0]  st;
    checkBit($sformatf("req_ready_idle_%0d", k), req_ready[k], 1'b1);
    req_valid[k] = 1'b1;
    drv_en[k]    = en;
    drv_data[k]  = d;
    @(posedge clk);
    #1;
    model(k, en, d, r, st);
    e.k = k; e.data = r; e.stale = st;
    sb.push_back(e);
    req_valid[k] = 1'b0;
    drv_en[k]    = ~en;
    drv_data[k]  = ~d;
  endtask

  task automatic checkOutput(input int k, input int stall, output logic [DW-1:0] got);
    int            edges;
    exp_t          e;
    logic [DW-1:0] held;
    edges = 0;
    while (res_valid[k] !== 1'b1 && edges < 8) begin
      @(posedge clk);
      #1;
      edges++;
    end
    checkValue($sformatf("latency_%0d", k), DW'(edges), DW'(2));
    got = res_data[k];
    if (sb.size() == 0) begin
      checkBit("scoreboard_empty", 1'b1, 1'b0);
    end else begin
      e = sb.pop_front();
      checkValue($sformatf("sb_inst_%0d", k), DW'(e.k), DW'(k));
      checkValue($sformatf("res_data_%0d", k), res_data[k], e.data);
      checkValue($sformatf("res_stale_%0d", k), DW'(res_stale[k]), DW'(e.stale));
    end
    held = res_data[k];
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      #1;
      checkBit($sformatf("bp_valid_%0d", s), res_valid[k], 1'b1);
      checkBit($sformatf("bp_req_ready_%0d", s), req_ready[k], 1'b0);
      checkValue($sformatf("bp_stable_%0d", s), res_data[k], held);
    end
    res_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    res_ready[k] = 1'b0;
    checkBit($sformatf("post_req_ready_%0d", k), req_ready[k], 1'b1);
    checkBit($sformatf("post_res_valid_%0d", k), res_valid[k], 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0;
      res_ready[k] = 1'b0;
      drv_en[k]    = '0;
      drv_data[k]  = '0;
      km[k]        = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checkBit($sformatf("rst_req_ready_%0d", k), req_ready[k], 1'b1);
      checkBit($sformatf("rst_res_valid_%0d", k), res_valid[k], 1'b0);
      checkValue($sformatf("rst_res_data_%0d", k), res_data[k], '0);
      checkValue($sformatf("rst_res_stale_%0d", k), DW'(res_stale[k]), '0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] OR full bus, edge lanes driven, 5 cycles backpressure");
    applyStimulus(0, 12'h801, 96'h8000_0000_0000_0000_0000_0001);
    checkOutput(0, 5, obs);
    checkValue("or_fullbus_literal", obs, 96'h8080_8181_8181_8181_8181_0101);

    $display("[TB] AND radius 1, lane 5 only");
    applyStimulus(1, 12'h020, 96'h0000_0000_0000_0F00_0000_0000);
    checkOutput(1, 0, obs);
    checkValue("and_r1_literal", obs, 96'hFFFF_FFFF_FF0F_0F0F_FFFF_FFFF);

    $display("[TB] keeper lane 0: drive then float");
    applyStimulus(2, 12'h001, 96'h0000_0000_0000_0000_0000_005A);
    checkOutput(2, 0, obs);
    checkValue("keep_drive_literal", obs, 96'h0000_0000_0000_0000_0000_005A);
    checkValue("keep_drive_stale", DW'(res_stale[2]), '0);
    applyStimulus(2, 12'h000, 96'h0);
    checkOutput(2, 0, obs);
    checkValue("keep_float_literal", obs, 96'h0000_0000_0000_0000_0000_005A);
    checkValue("keep_float_stale", DW'(res_stale[2]), DW'(12'h001));

    $display("[TB] reset during EVAL");
    applyStimulus(2, 12'h001, 96'h0000_0000_0000_0000_0000_00A5);
    @(posedge clk);
    #1;
    checkBit("abort_eval_valid", res_valid[2], 1'b0);
    rst_n = 1'b0;
    #1;
    checkBit("abort_req_ready", req_ready[2], 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checkBit($sformatf("abort_valid_%0d", c), res_valid[2], 1'b0);
    end
    sb.delete();
    for (int k = 0; k < 3; k++) km[k] = '0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkBit("abort_release_valid", res_valid[2], 1'b0);
    checkBit("abort_release_ready", req_ready[2], 1'b1);
    applyStimulus(2, 12'h000, 96'h0);
    checkOutput(2, 0, obs);
    checkValue("keeper_cleared", obs, '0);
    checkValue("keeper_cleared_stale", DW'(res_stale[2]), DW'(12'h001));
    applyStimulus(2, 12'h001, 96'h0000_0000_0000_0000_0000_003C);
    checkOutput(2, 0, obs);
    checkValue("post_reset_txn", obs, 96'h0000_0000_0000_0000_0000_003C);

    $display("[TB] radius 0, every lane driving its own value");
    applyStimulus(2, 12'hFFF, 96'h1B1A_1918_1716_1514_1312_1110);
    checkOutput(2, 0, obs);
    checkValue("r0_isolation", obs, 96'h1B1A_1918_1716_1514_1312_1110);

    $display("[TB] random traffic");
    for (int n = 0; n < 6; n++) begin
      int k;
      k = n % 3;
      applyStimulus(k, L'($urandom_range(0, 4095)), {$urandom, $urandom, $urandom});
      checkOutput(k, n % 2, obs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
